// File: rtl/regbank_pkg.sv
// Shared definitions for the banked register file: mode encodings, physical
// register indices, CPSR bit positions and the exception sequencer states.
package regbank_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int unsigned CPSR_I       = 7;
  localparam int unsigned CPSR_F       = 6;
  localparam int unsigned CPSR_MODE_HI = 4;
  localparam int unsigned CPSR_MODE_LO = 0;
  localparam logic [31:0] CPSR_RST     = 32'h0000_00D3;

  // R15 lives in its own register, so the array holds the other 30 GPRs
  localparam int unsigned NUM_GPR  = 30;
  localparam int unsigned NUM_SPSR = 5;
  localparam int unsigned PHYS_W   = 5;
  localparam int unsigned SPSR_W   = 3;

  localparam logic [PHYS_W-1:0] PHYS_USR_R13 = 5'd13;
  localparam logic [PHYS_W-1:0] PHYS_FIQ_R8  = 5'd15;
  localparam logic [PHYS_W-1:0] PHYS_FIQ_R13 = 5'd20;
  localparam logic [PHYS_W-1:0] PHYS_IRQ_R13 = 5'd22;
  localparam logic [PHYS_W-1:0] PHYS_SVC_R13 = 5'd24;
  localparam logic [PHYS_W-1:0] PHYS_ABT_R13 = 5'd26;
  localparam logic [PHYS_W-1:0] PHYS_UND_R13 = 5'd28;

  typedef enum logic [1:0] {IDLE, SAVE, SWITCH} exc_state_t;

  typedef enum logic [2:0] {
    BANK_USR, BANK_FIQ, BANK_IRQ, BANK_SVC, BANK_ABT, BANK_UND
  } bank_t;

  // SYS and every unrecognised encoding share the USR bank
  function automatic bank_t mode_bank(input logic [4:0] mode);
    case (mode)
      MODE_FIQ: return BANK_FIQ;
      MODE_IRQ: return BANK_IRQ;
      MODE_SVC: return BANK_SVC;
      MODE_ABT: return BANK_ABT;
      MODE_UND: return BANK_UND;
      default:  return BANK_USR;
    endcase
  endfunction

  function automatic logic [PHYS_W-1:0] r13_phys(input bank_t bank);
    case (bank)
      BANK_FIQ: return PHYS_FIQ_R13;
      BANK_IRQ: return PHYS_IRQ_R13;
      BANK_SVC: return PHYS_SVC_R13;
      BANK_ABT: return PHYS_ABT_R13;
      BANK_UND: return PHYS_UND_R13;
      default:  return PHYS_USR_R13;
    endcase
  endfunction

  // Only meaningful for privileged banks; USR/SYS own no SPSR
  function automatic logic [SPSR_W-1:0] spsr_idx(input bank_t bank);
    return SPSR_W'(bank) - SPSR_W'(1);
  endfunction

endpackage

// File: rtl/regbank_addr_map.sv
// Combinational translation of (mode, architectural register) to a physical
// GPR index, flagging R15 separately since the PC is held outside the array.
module regbank_addr_map
  import regbank_pkg::*;
(
  input  logic [4:0]        mode,
  input  logic [3:0]        arch_reg,
  output logic [PHYS_W-1:0] phys_idx_c,
  output logic              is_pc_c
);

  bank_t bank;

  always_comb begin
    bank       = mode_bank(mode);
    phys_idx_c = PHYS_W'(arch_reg);
    is_pc_c    = 1'b0;
    if (arch_reg == 4'd15) begin
      is_pc_c    = 1'b1;
      phys_idx_c = '0;
    end else if (arch_reg >= 4'd13) begin
      phys_idx_c = r13_phys(bank) + PHYS_W'(arch_reg - 4'd13);
    end else if (arch_reg >= 4'd8 && bank == BANK_FIQ) begin
      phys_idx_c = PHYS_FIQ_R8 + PHYS_W'(arch_reg - 4'd8);
    end
  end

endmodule

// File: rtl/banked_regfile.sv
// ARM banked register file with registered read ports, PC/CPSR/SPSR access and
// an exception-entry sequencer. Define REGBANK_FWD_EN for write-to-read bypass.
module banked_regfile
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_RD  = 3,
  parameter int unsigned PC_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_wr_en,
  input  logic [DATA_W-1:0]        pc_wr_data,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc,
  input  logic                     cpsr_wr_en,
  input  logic [31:0]              cpsr_wr_data,
  input  logic [31:0]              cpsr_mask,
  output logic [31:0]              cpsr,
  input  logic                     spsr_wr_en,
  input  logic [31:0]              spsr_wr_data,
  output logic [31:0]              spsr,
  input  logic                     exc_req,
  input  logic [4:0]               exc_mode,
  input  logic [DATA_W-1:0]        exc_vector,
  input  logic [DATA_W-1:0]        exc_ret_addr,
  output logic                     exc_busy,
  output logic                     exc_done
);

  logic [DATA_W-1:0] gpr_q  [NUM_GPR];
  logic [31:0]       spsr_q [NUM_SPSR];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [DATA_W-1:0] rd_val    [NUM_RD];
  logic [PHYS_W-1:0] rd_phys   [NUM_RD];
  logic              rd_is_pc  [NUM_RD];
  logic [DATA_W-1:0] pc_q, pc_d, exc_vector_q, exc_ret_q;
  logic [31:0]       cpsr_q, cpsr_d;
  logic [4:0]        exc_mode_q;
  logic [PHYS_W-1:0] wr_phys;
  logic              wr_is_pc;
  exc_state_t        state_q, state_d;
  logic              busy_q, done_q, do_save, do_switch, busy_c, exc_accept;
  bank_t             cur_bank, exc_bank;

  assign cur_bank   = mode_bank(cpsr_q[CPSR_MODE_HI:CPSR_MODE_LO]);
  assign exc_bank   = mode_bank(exc_mode_q);
  assign busy_c     = (state_q != IDLE);
  assign exc_accept = (state_q == IDLE) && exc_req && (mode_bank(exc_mode) != BANK_USR);

  regbank_addr_map u_wr_map (
    .mode       (cpsr_q[CPSR_MODE_HI:CPSR_MODE_LO]),
    .arch_reg   (wr_addr),
    .phys_idx_c (wr_phys),
    .is_pc_c    (wr_is_pc)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regbank_addr_map u_rd_map (
      .mode       (cpsr_q[CPSR_MODE_HI:CPSR_MODE_LO]),
      .arch_reg   (rd_addr[4*k +: 4]),
      .phys_idx_c (rd_phys[k]),
      .is_pc_c    (rd_is_pc[k])
    );
    assign rd_data[DATA_W*k +: DATA_W] = rd_data_q[k];
  end

  // Exception sequencer: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == SWITCH);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (exc_accept) state_d = SAVE;
      SAVE:    state_d = SWITCH;
      SWITCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    do_save   = 1'b0;
    do_switch = 1'b0;
    case (state_q)
      SAVE:    do_save   = 1'b1;
      SWITCH:  do_switch = 1'b1;
      default: ;
    endcase
  end

  // PC and CPSR next values with exception entry taking precedence
  always_comb begin
    pc_d   = pc_q;
    cpsr_d = cpsr_q;
    if (do_switch) begin
      pc_d = exc_vector_q;
      cpsr_d[CPSR_MODE_HI:CPSR_MODE_LO] = exc_mode_q;
      cpsr_d[CPSR_I] = 1'b1;
      if (exc_mode_q == MODE_FIQ) cpsr_d[CPSR_F] = 1'b1;
    end else if (!busy_c) begin
      if (pc_wr_en)                pc_d = pc_wr_data;
      else if (wr_en && wr_is_pc)  pc_d = wr_data;
      else if (pc_inc)             pc_d = pc_q + DATA_W'(PC_STEP);
      if (cpsr_wr_en) cpsr_d = (cpsr_q & ~cpsr_mask) | (cpsr_wr_data & cpsr_mask);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_val[k] = rd_is_pc[k] ? pc_q : gpr_q[rd_phys[k]];
`ifdef REGBANK_FWD_EN
      if (wr_en && !busy_c && wr_is_pc && rd_is_pc[k]) begin
        rd_val[k] = pc_d;
      end else if (wr_en && !busy_c && !wr_is_pc && !rd_is_pc[k] && rd_phys[k] == wr_phys) begin
        rd_val[k] = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++)  gpr_q[i]  <= '0;
      for (int i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
      for (int k = 0; k < NUM_RD; k++)   rd_data_q[k] <= '0;
      pc_q         <= '0;
      cpsr_q       <= CPSR_RST;
      exc_mode_q   <= '0;
      exc_vector_q <= '0;
      exc_ret_q    <= '0;
    end else begin
      pc_q   <= pc_d;
      cpsr_q <= cpsr_d;
      if (rd_en) begin
        for (int k = 0; k < NUM_RD; k++) rd_data_q[k] <= rd_val[k];
      end
      if (exc_accept) begin
        exc_mode_q   <= exc_mode;
        exc_vector_q <= exc_vector;
        exc_ret_q    <= exc_ret_addr;
      end
      if (wr_en && !busy_c && !wr_is_pc) gpr_q[wr_phys] <= wr_data;
      if (spsr_wr_en && !busy_c && cur_bank != BANK_USR) spsr_q[spsr_idx(cur_bank)] <= spsr_wr_data;
      if (do_save) begin
        spsr_q[spsr_idx(exc_bank)] <= cpsr_q;
        gpr_q[r13_phys(exc_bank) + PHYS_W'(1)] <= exc_ret_q;
      end
    end
  end

  assign pc       = pc_q;
  assign cpsr     = cpsr_q;
  assign spsr     = (cur_bank == BANK_USR) ? 32'h0 : spsr_q[spsr_idx(cur_bank)];
  assign exc_busy = busy_q;
  assign exc_done = done_q;

endmodule

// File: tb/tb_banked_regfile.sv
// Directed self-checking bench for banked_regfile (default 32-bit, 3 read ports).
module tb_banked_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_wr_en;
  logic [31:0] pc_wr_data;
  logic        pc_inc;
  logic [31:0] pc;
  logic        cpsr_wr_en;
  logic [31:0] cpsr_wr_data, cpsr_mask, cpsr;
  logic        spsr_wr_en;
  logic [31:0] spsr_wr_data, spsr;
  logic        exc_req;
  logic [4:0]  exc_mode;
  logic [31:0] exc_vector, exc_ret_addr;
  logic        exc_busy, exc_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  banked_regfile dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_inc(pc_inc), .pc(pc),
    .cpsr_wr_en(cpsr_wr_en), .cpsr_wr_data(cpsr_wr_data), .cpsr_mask(cpsr_mask), .cpsr(cpsr),
    .spsr_wr_en(spsr_wr_en), .spsr_wr_data(spsr_wr_data), .spsr(spsr),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_vector(exc_vector),
    .exc_ret_addr(exc_ret_addr), .exc_busy(exc_busy), .exc_done(exc_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_port(input int k);
    return rd_data[32*k +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read3(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    rd_en = 1'b1; rd_addr = {a2, a1, a0};
    tick();
    rd_en = 1'b0;
  endtask

  task automatic set_cpsr(input logic [31:0] d, input logic [31:0] m);
    cpsr_wr_en = 1'b1; cpsr_wr_data = d; cpsr_mask = m;
    tick();
    cpsr_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    pc_wr_en = 0; pc_wr_data = '0; pc_inc = 0; cpsr_wr_en = 0; cpsr_wr_data = '0;
    cpsr_mask = '0; spsr_wr_en = 0; spsr_wr_data = '0; exc_req = 0; exc_mode = '0;
    exc_vector = '0; exc_ret_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_cpsr", cpsr, 32'hD3);
    check_eq("rst_busy", 32'(exc_busy), 32'h0);
    check_eq("rst_done", 32'(exc_done), 32'h0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_spsr", spsr, 32'h0);
    for (int r = 0; r < 16; r += 3) begin
      read3(4'(r), 4'(r + 1), 4'(r + 2));
      for (int k = 0; k < 3; k++)
        check_eq($sformatf("rst_r%0d", (r + k) % 16), rd_port(k), 32'h0);
    end

    // Banking across SVC / FIQ / USR / SYS
    write_reg(4'd13, 32'h1111);
    set_cpsr(32'h11, 32'h1F);
    check_eq("cpsr_fiq", cpsr, 32'hD1);
    write_reg(4'd13, 32'h2222);
    write_reg(4'd8, 32'h3333);
    read3(4'd13, 4'd8, 4'd14);
    check_eq("fiq_r13", rd_port(0), 32'h2222);
    check_eq("fiq_r8", rd_port(1), 32'h3333);
    check_eq("fiq_r14", rd_port(2), 32'h0);
    set_cpsr(32'h10, 32'h1F);
    read3(4'd13, 4'd8, 4'd0);
    check_eq("usr_r13", rd_port(0), 32'h0);
    check_eq("usr_r8", rd_port(1), 32'h0);
    set_cpsr(32'h1F, 32'h1F);
    write_reg(4'd13, 32'h5555);
    set_cpsr(32'h10, 32'h1F);
    read3(4'd13, 4'd0, 4'd0);
    check_eq("sys_usr_shared_r13", rd_port(0), 32'h5555);
    set_cpsr(32'h13, 32'h1F);
    read3(4'd13, 4'd8, 4'd15);
    check_eq("svc_r13", rd_port(0), 32'h1111);
    check_eq("svc_r8", rd_port(1), 32'h0);
    check_eq("svc_r15", rd_port(2), 32'h0);

    // SPSR write in SVC, ignored in USR
    spsr_wr_en = 1'b1; spsr_wr_data = 32'hA5;
    tick();
    spsr_wr_en = 1'b0;
    check_eq("spsr_svc", spsr, 32'hA5);
    set_cpsr(32'h10, 32'h1F);
    spsr_wr_en = 1'b1; spsr_wr_data = 32'h5A;
    tick();
    spsr_wr_en = 1'b0;
    check_eq("spsr_usr", spsr, 32'h0);

    // PC priority and wrap
    pc_inc = 1'b1; pc_wr_en = 1'b1; pc_wr_data = 32'h100;
    tick();
    pc_wr_en = 1'b0;
    check_eq("pc_wr_over_inc", pc, 32'h100);
    tick();
    pc_inc = 1'b0;
    check_eq("pc_inc", pc, 32'h104);
    pc_inc = 1'b1; wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h200;
    tick();
    check_eq("pc_r15_over_inc", pc, 32'h200);
    pc_wr_en = 1'b1; pc_wr_data = 32'h300; wr_data = 32'h400;
    tick();
    pc_inc = 1'b0; pc_wr_en = 1'b0; wr_en = 1'b0;
    check_eq("pc_wr_over_r15", pc, 32'h300);
    read3(4'd15, 4'd0, 4'd0);
    check_eq("read_r15", rd_port(0), 32'h300);
    pc_wr_en = 1'b1; pc_wr_data = 32'hFFFF_FFFC;
    tick();
    pc_wr_en = 1'b0; pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check_eq("pc_wrap", pc, 32'h0);
    pc_wr_en = 1'b1; pc_wr_data = 32'h8000;
    tick();
    pc_wr_en = 1'b0;

    // Exception entry: invalid mode ignored, then IRQ
    set_cpsr(32'h10, 32'hFFFF_FFFF);
    check_eq("cpsr_full", cpsr, 32'h10);
    exc_req = 1'b1; exc_mode = 5'h10; exc_vector = 32'h44; exc_ret_addr = 32'h44;
    tick();
    check_eq("exc_usr_ignored", 32'(exc_busy), 32'h0);
    exc_mode = 5'h12; exc_vector = 32'h18; exc_ret_addr = 32'h8004;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h77;
    tick();
    exc_req = 1'b0; exc_mode = 5'h11; exc_vector = 32'h99; exc_ret_addr = 32'h99;
    check_eq("exc_busy_n1", 32'(exc_busy), 32'h1);
    check_eq("exc_done_n1", 32'(exc_done), 32'h0);
    wr_addr = 4'd1; wr_data = 32'h99; pc_inc = 1'b1;
    cpsr_wr_en = 1'b1; cpsr_wr_data = 32'h1F; cpsr_mask = 32'hFF; spsr_wr_en = 1'b1;
    tick();
    wr_en = 1'b0; pc_inc = 1'b0; cpsr_wr_en = 1'b0; spsr_wr_en = 1'b0;
    check_eq("exc_busy_n2", 32'(exc_busy), 32'h1);
    check_eq("exc_done_n2", 32'(exc_done), 32'h1);
    check_eq("exc_pc_held", pc, 32'h8000);
    tick();
    check_eq("exc_busy_n3", 32'(exc_busy), 32'h0);
    check_eq("exc_done_n3", 32'(exc_done), 32'h0);
    check_eq("exc_cpsr", cpsr, 32'h92);
    check_eq("exc_pc", pc, 32'h18);
    check_eq("exc_spsr_irq", spsr, 32'h10);
    read3(4'd14, 4'd0, 4'd1);
    check_eq("exc_r14_irq", rd_port(0), 32'h8004);
    check_eq("accept_cycle_wr", rd_port(1), 32'h77);
    check_eq("busy_wr_ignored", rd_port(2), 32'h0);

    // Same-cycle write/read of R3
    write_reg(4'd3, 32'h1234);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hABCD;
    rd_en = 1'b1; rd_addr = {4'd0, 4'd0, 4'd3};
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
`ifdef REGBANK_FWD_EN
    check_eq("fwd_r3", rd_port(0), 32'hABCD);
`else
    check_eq("fwd_r3", rd_port(0), 32'h1234);
`endif
    read3(4'd3, 4'd0, 4'd0);
    check_eq("after_wr_r3", rd_port(0), 32'hABCD);

    // Reset asserted during SAVE
    exc_req = 1'b1; exc_mode = 5'h11; exc_vector = 32'h1C; exc_ret_addr = 32'h55;
    tick();
    exc_req = 1'b0;
    check_eq("save_busy", 32'(exc_busy), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("midrst_cpsr", cpsr, 32'hD3);
    check_eq("midrst_busy", 32'(exc_busy), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("midrst_pc", pc, 32'h0);
    check_eq("midrst_cpsr2", cpsr, 32'hD3);
    check_eq("midrst_spsr_svc", spsr, 32'h0);
    read3(4'd14, 4'd13, 4'd3);
    check_eq("midrst_r14_svc", rd_port(0), 32'h0);
    check_eq("midrst_r13_svc", rd_port(1), 32'h0);
    check_eq("midrst_r3", rd_port(2), 32'h0);
    set_cpsr(32'h12, 32'h1F);
    check_eq("midrst_spsr_irq", spsr, 32'h0);
    read3(4'd14, 4'd0, 4'd0);
    check_eq("midrst_r14_irq", rd_port(0), 32'h0);
    set_cpsr(32'h11, 32'h1F);
    check_eq("midrst_spsr_fiq", spsr, 32'h0);
    read3(4'd14, 4'd0, 4'd0);
    check_eq("midrst_r14_fiq", rd_port(0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
